// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one start/busy word transmitter between N_REQ producers.
// Define UART_TX_SCHED_TAG_EN to stamp the granted index into tx_data[DATA_W-1 -: 4].
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 32,
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W        = 16,
  localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [IDW-1:0]          grant_id,
  output logic                    active,
  output logic                    err_timeout,
  output logic [CNT_W-1:0]        frames_sent
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state_reg, state_next;
  logic [N_REQ-1:0]    ack_reg, ack_next;
  logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
  logic                tx_start_reg, tx_start_next;
  logic [IDW-1:0]      grant_id_reg, grant_id_next;
  logic                active_reg, active_next;
  logic                err_reg, err_next;
  logic [CNT_W-1:0]    frames_reg, frames_next;
  logic [7:0]          tmo_cnt_reg, tmo_cnt_next;

  logic [DATA_W-1:0]   req_word [N_REQ];
  logic [IDW-1:0]      sel;
  logic                found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Rotating priority: first pass looks above the last grant, second pass wraps to the bottom.
  always_comb begin
    sel   = grant_id_reg;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k] && (IDW'(k) > grant_id_reg)) begin
        found = 1'b1;
        sel   = IDW'(k);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        sel   = IDW'(k);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ack_next      = '0;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    grant_id_next = grant_id_reg;
    active_next   = active_reg;
    err_next      = err_reg;
    frames_next   = frames_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (found && !tx_busy) begin
`ifdef UART_TX_SCHED_TAG_EN
          tx_data_next = {4'(sel), req_word[sel][DATA_W-5:0]};
`else
          tx_data_next = req_word[sel];
`endif
          grant_id_next = sel;
          ack_next[sel] = 1'b1;
          tx_start_next = 1'b1;
          active_next   = 1'b1;
          state_next    = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_cnt_next = '0;
        state_next   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (tmo_cnt_reg == 8'(BUSY_TIMEOUT - 1)) begin
          err_next    = 1'b1;
          active_next = 1'b0;
          state_next  = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frames_next = frames_reg + CNT_W'(1);
          active_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ack_reg      <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      grant_id_reg <= IDW'(N_REQ - 1);
      active_reg   <= 1'b0;
      err_reg      <= 1'b0;
      frames_reg   <= '0;
      tmo_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      ack_reg      <= ack_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      grant_id_reg <= grant_id_next;
      active_reg   <= active_next;
      err_reg      <= err_next;
      frames_reg   <= frames_next;
      tmo_cnt_reg  <= tmo_cnt_next;
    end
  end

  assign ack         = ack_reg;
  assign tx_data     = tx_data_reg;
  assign tx_start    = tx_start_reg;
  assign grant_id    = grant_id_reg;
  assign active      = active_reg;
  assign err_timeout = err_reg;
  assign frames_sent = frames_reg;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one 32-bit serial word transmitter (start/busy interface, 100 MHz, 115200 baud) between N_REQ producers, e.g. ECG channel samplers and a status reporter.
- Latches the winning producer's word, pulses the transmitter start for one cycle, then tracks its busy flag until the word has left.
- Sits between the sample/packet producers and the UART transmitter.
- Provides per-requester acknowledge, a frame counter and a sticky launch-timeout error.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 32, word width; must match the transmitter data_in width.
- BUSY_TIMEOUT, 16, max cycles allowed after start for tx_busy to rise; legal range 2..255.
- CNT_W, 16, width of frames_sent.
- Derived localparam IDW = clog2(N_REQ), minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req  in  N_REQ  per-requester request; level, held until ack
- req_data  in  N_REQ*DATA_W  packed words; requester i in bits [i*DATA_W +: DATA_W]
- ack  out  N_REQ  one-hot, one-cycle pulse: word i captured
- tx_data  out  DATA_W  word to transmitter data_in
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_busy  in  1  transmitter busy flag
- grant_id  out  IDW  index of the current or last granted requester
- active  out  1  high from grant until the transmitter releases busy
- err_timeout  out  1  sticky: tx_busy failed to rise within BUSY_TIMEOUT
- frames_sent  out  CNT_W  count of completed words; wraps

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE.
  - ack=0, tx_start=0, tx_data=0, grant_id=N_REQ-1 (so requester 0 has first priority), active=0, err_timeout=0, frames_sent=0, timeout counter=0.
  - Reset mid-transfer abandons the transfer. No ack and no count for it. The transmitter is not reset by this block.
- All outputs are registered.
- FSM states:
  - IDLE: if any req bit is high and tx_busy=0, select the first set bit searching from grant_id+1 upward with modulo-N_REQ wrap. On that edge: tx_data<=req_data[sel], grant_id<=sel, ack[sel]<=1, tx_start<=1, active<=1, go to LAUNCH. If tx_busy=1 (foreign or left-over transfer), stay in IDLE and grant nothing.
  - LAUNCH: exactly one cycle. ack<=0, tx_start<=0, timeout counter cleared, go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0: err_timeout<=1, active<=0, go to IDLE, frames_sent unchanged.
  - WAIT_DONE: when tx_busy=0, frames_sent<=frames_sent+1 (wraps at 2^CNT_W), active<=0, go to IDLE.
- Latency: req sampled high in IDLE -> ack and tx_start high on the next cycle (1 cycle).
- Back-to-back: the earliest next grant is the edge after the WAIT_DONE->IDLE edge.
- tx_data holds the captured word from grant until the next grant. Producers may change req_data after ack.
- A requester dropping req before ack is a legal withdrawal with no side effect. A request present only while the FSM is not in IDLE is not remembered.
- Fairness: a requester that holds req continuously is granted within N_REQ grants.
- Simultaneous requests: resolved only by the rotating priority.
- The requester granted last has lowest priority in the next arbitration.
- err_timeout clears only on reset. Arbitration continues after an error.

Optional Feature:
- Macro: UART_TX_SCHED_TAG_EN.
- Defined: tx_data[DATA_W-1 -: 4] is replaced by the granted index, zero-extended to 4 bits. The remaining bits are taken from req_data unchanged. This lets the receiver demultiplex channels. Requires N_REQ<=16.
- Undefined: tx_data equals req_data[sel] verbatim and there is no tag logic.

Test Plan:
- Single request: req=4'b0100, req_data[2]=32'hDEADBEEF, transmitter model raises busy 1 cycle after start and holds it 100 cycles -> ack=4'b0100 for 1 cycle, tx_start 1 cycle, tx_data=32'hDEADBEEF, grant_id=2, frames_sent=1, active low after busy falls.
- Round robin: req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3, each ack exactly once per turn, frames_sent=8.
- Timeout: transmitter model never asserts busy, BUSY_TIMEOUT=16 -> err_timeout=1 within 18 cycles of tx_start, frames_sent=0. Then a normal transfer completes, frames_sent=1 and err_timeout stays 1.
- Reset mid-operation: rst_n=0 during WAIT_DONE for 1 cycle -> all outputs at reset values the next cycle, grant_id=N_REQ-1, no ack for a pending req until IDLE with tx_busy=0.
- Wrap and foreign busy: CNT_W=4 with 17 transfers -> frames_sent=1. tx_busy forced 1 in IDLE with req=4'b0001 -> no ack until busy drops.
- UART_TX_SCHED_TAG_EN defined: req_data[3]=32'h0123_4567 -> tx_data=32'h3123_4567. Undefined -> tx_data=32'h0123_4567.
